// File: rtl/axi_pkg.sv
// Shared AXI3 constants and the burst-master state encoding.
package axi_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        WR_ADDR,
        WR_DATA,
        WR_RESP,
        RD_ADDR,
        RD_DATA
    } burst_state_e;

endpackage

// File: rtl/axi_burst_master.sv
// Single-outstanding AXI3 INCR burst master with pass-through data streams.
// Optional no-progress watchdog enabled by defining AXI_BURST_MASTER_TIMEOUT_EN.
module axi_burst_master
    import axi_pkg::*;
#(
    parameter int DataBits      = 64,
    parameter int AxiAddrBits   = 32,
    parameter int TimeoutCycles = 1024
) (
    input  logic                     clk,
    input  logic                     rst_n,

    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic                     cmd_write,
    input  logic [AxiAddrBits-1:0]   cmd_addr,
    input  logic [3:0]               cmd_len,

    input  logic                     wr_valid,
    output logic                     wr_ready,
    input  logic [DataBits-1:0]      wr_data,

    output logic                     rd_valid,
    input  logic                     rd_ready,
    output logic [DataBits-1:0]      rd_data,
    output logic                     rd_last,

    output logic                     done,
    output logic                     err,
    output logic                     timeout,

    output logic [3:0]               mst_awid,
    output logic [AxiAddrBits-1:0]   mst_awaddr,
    output logic [3:0]               mst_awlen,
    output logic [2:0]               mst_awsize,
    output logic [1:0]               mst_awburst,
    output logic [1:0]               mst_awlock,
    output logic [3:0]               mst_awcache,
    output logic [2:0]               mst_awprot,
    output logic                     mst_awvalid,
    input  logic                     mst_awready,

    output logic [3:0]               mst_wid,
    output logic [DataBits-1:0]      mst_wdata,
    output logic [DataBits/8-1:0]    mst_wstrb,
    output logic                     mst_wlast,
    output logic                     mst_wvalid,
    input  logic                     mst_wready,

    input  logic [3:0]               mst_bid,
    input  logic [1:0]               mst_bresp,
    input  logic                     mst_bvalid,
    output logic                     mst_bready,

    output logic [3:0]               mst_arid,
    output logic [AxiAddrBits-1:0]   mst_araddr,
    output logic [3:0]               mst_arlen,
    output logic [2:0]               mst_arsize,
    output logic [1:0]               mst_arburst,
    output logic [1:0]               mst_arlock,
    output logic [3:0]               mst_arcache,
    output logic [2:0]               mst_arprot,
    output logic                     mst_arvalid,
    input  logic                     mst_arready,

    input  logic [3:0]               mst_rid,
    input  logic [DataBits-1:0]      mst_rdata,
    input  logic [1:0]               mst_rresp,
    input  logic                     mst_rlast,
    input  logic                     mst_rvalid,
    output logic                     mst_rready
);

    localparam int ByteBits = $clog2(DataBits / 8);
    localparam logic [AxiAddrBits-1:0] AlignMask =
        ~((AxiAddrBits'(1) << ByteBits) - AxiAddrBits'(1));

    burst_state_e           state_reg, state_next;
    logic [AxiAddrBits-1:0] addr_reg;
    logic [3:0]             len_reg;
    logic [3:0]             beat_reg;
    logic                   awvalid_reg, arvalid_reg;
    logic                   rd_err_reg;
    logic                   done_reg, err_reg;
    logic                   done_next, err_next;

    logic in_wr, in_rd;
    logic cmd_hs, aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic last_beat, beat_err;

    assign in_wr     = (state_reg == WR_DATA);
    assign in_rd     = (state_reg == RD_DATA);
    assign cmd_ready = (state_reg == IDLE);

    assign cmd_hs = cmd_valid & cmd_ready;
    assign aw_hs  = awvalid_reg & mst_awready;
    assign ar_hs  = arvalid_reg & mst_arready;
    assign w_hs   = mst_wvalid & mst_wready;
    assign b_hs   = mst_bvalid & mst_bready;
    assign r_hs   = mst_rvalid & mst_rready;

    assign last_beat = (beat_reg == len_reg);
    // A beat is bad if the slave flags it or its rlast disagrees with our own count.
    assign beat_err  = (mst_rresp != RESP_OKAY) | (mst_rlast != last_beat);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        done_next  = 1'b0;
        err_next   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (cmd_hs) begin
                    state_next = cmd_write ? WR_ADDR : RD_ADDR;
                end
            end
            WR_ADDR: begin
                if (aw_hs) begin
                    state_next = WR_DATA;
                end
            end
            WR_DATA: begin
                if (w_hs && last_beat) begin
                    state_next = WR_RESP;
                end
            end
            WR_RESP: begin
                if (b_hs) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                    err_next   = (mst_bresp != RESP_OKAY);
                end
            end
            RD_ADDR: begin
                if (ar_hs) begin
                    state_next = RD_DATA;
                end
            end
            RD_DATA: begin
                // Beat count alone ends the burst; an early rlast only raises err.
                if (r_hs && last_beat) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                    err_next   = rd_err_reg | beat_err;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_reg    <= '0;
            len_reg     <= '0;
            beat_reg    <= '0;
            awvalid_reg <= 1'b0;
            arvalid_reg <= 1'b0;
            rd_err_reg  <= 1'b0;
            done_reg    <= 1'b0;
            err_reg     <= 1'b0;
        end else begin
            if (cmd_hs) begin
                addr_reg <= cmd_addr;
                len_reg  <= cmd_len;
            end
            awvalid_reg <= (state_next == WR_ADDR);
            arvalid_reg <= (state_next == RD_ADDR);
            if (aw_hs || ar_hs) begin
                beat_reg <= '0;
            end else if (w_hs || r_hs) begin
                beat_reg <= beat_reg + 4'd1;
            end
            if (ar_hs) begin
                rd_err_reg <= 1'b0;
            end else if (r_hs) begin
                rd_err_reg <= rd_err_reg | beat_err;
            end
            done_reg <= done_next;
            err_reg  <= err_next;
        end
    end

    assign done = done_reg;
    assign err  = err_reg;

    assign mst_awid    = '0;
    assign mst_awaddr  = addr_reg & AlignMask;
    assign mst_awlen   = len_reg;
    assign mst_awsize  = 3'(ByteBits);
    assign mst_awburst = BURST_INCR;
    assign mst_awlock  = '0;
    assign mst_awcache = '0;
    assign mst_awprot  = '0;
    assign mst_awvalid = awvalid_reg;

    assign mst_wid    = '0;
    assign mst_wdata  = wr_data;
    assign mst_wstrb  = '1;
    assign mst_wlast  = in_wr & last_beat;
    assign mst_wvalid = in_wr & wr_valid;
    assign wr_ready   = in_wr & mst_wready;

    assign mst_bready = (state_reg == WR_RESP);

    assign mst_arid    = '0;
    assign mst_araddr  = addr_reg & AlignMask;
    assign mst_arlen   = len_reg;
    assign mst_arsize  = 3'(ByteBits);
    assign mst_arburst = BURST_INCR;
    assign mst_arlock  = '0;
    assign mst_arcache = '0;
    assign mst_arprot  = '0;
    assign mst_arvalid = arvalid_reg;

    assign rd_valid   = in_rd & mst_rvalid;
    assign mst_rready = in_rd & rd_ready;
    assign rd_data    = in_rd ? mst_rdata : '0;
    assign rd_last    = in_rd & last_beat;

    // Response ids are irrelevant with a single burst outstanding.
    logic unused_ids;
    assign unused_ids = ^{mst_bid, mst_rid};

`ifdef AXI_BURST_MASTER_TIMEOUT_EN
    localparam int ToBits = $clog2(TimeoutCycles + 1);
    localparam logic [ToBits-1:0] ToLimit = ToBits'(TimeoutCycles);

    logic [ToBits-1:0] to_cnt_reg;
    logic              timeout_reg;
    logic              any_hs;

    assign any_hs = aw_hs | w_hs | b_hs | ar_hs | r_hs;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt_reg  <= '0;
            timeout_reg <= 1'b0;
        end else begin
            if (cmd_ready || any_hs) begin
                to_cnt_reg <= '0;
            end else if (to_cnt_reg != ToLimit) begin
                to_cnt_reg <= to_cnt_reg + 1'b1;
            end
            if (to_cnt_reg == ToLimit) begin
                timeout_reg <= 1'b1;
            end
        end
    end

    assign timeout = timeout_reg;
`else
    localparam int unused_timeout_cycles = TimeoutCycles;
    assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_axi_burst_master.sv
// Scoreboard bench for axi_burst_master against an inline AXI3 slave memory model.
module tb_axi_burst_master;
    import axi_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr;
    logic [3:0]  cmd_len;
    logic        wr_valid, wr_ready;
    logic [63:0] wr_data;
    logic        rd_valid, rd_ready, rd_last;
    logic [63:0] rd_data;
    logic        done, err, timeout;
    logic [3:0]  mst_awid, mst_awlen, mst_awcache, mst_wid, mst_bid, mst_arid, mst_arlen, mst_arcache, mst_rid;
    logic [31:0] mst_awaddr, mst_araddr;
    logic [2:0]  mst_awsize, mst_awprot, mst_arsize, mst_arprot;
    logic [1:0]  mst_awburst, mst_awlock, mst_arburst, mst_arlock, mst_bresp, mst_rresp;
    logic        mst_awvalid, mst_awready, mst_wlast, mst_wvalid, mst_wready;
    logic        mst_bvalid, mst_bready, mst_arvalid, mst_arready;
    logic        mst_rlast, mst_rvalid, mst_rready;
    logic [63:0] mst_wdata, mst_rdata;
    logic [7:0]  mst_wstrb;

    always #5 clk = ~clk;

    axi_burst_master #(.DataBits(64), .AxiAddrBits(32), .TimeoutCycles(1024)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
        .done(done), .err(err), .timeout(timeout),
        .mst_awid(mst_awid), .mst_awaddr(mst_awaddr), .mst_awlen(mst_awlen), .mst_awsize(mst_awsize),
        .mst_awburst(mst_awburst), .mst_awlock(mst_awlock), .mst_awcache(mst_awcache),
        .mst_awprot(mst_awprot), .mst_awvalid(mst_awvalid), .mst_awready(mst_awready),
        .mst_wid(mst_wid), .mst_wdata(mst_wdata), .mst_wstrb(mst_wstrb), .mst_wlast(mst_wlast),
        .mst_wvalid(mst_wvalid), .mst_wready(mst_wready),
        .mst_bid(mst_bid), .mst_bresp(mst_bresp), .mst_bvalid(mst_bvalid), .mst_bready(mst_bready),
        .mst_arid(mst_arid), .mst_araddr(mst_araddr), .mst_arlen(mst_arlen), .mst_arsize(mst_arsize),
        .mst_arburst(mst_arburst), .mst_arlock(mst_arlock), .mst_arcache(mst_arcache),
        .mst_arprot(mst_arprot), .mst_arvalid(mst_arvalid), .mst_arready(mst_arready),
        .mst_rid(mst_rid), .mst_rdata(mst_rdata), .mst_rresp(mst_rresp), .mst_rlast(mst_rlast),
        .mst_rvalid(mst_rvalid), .mst_rready(mst_rready)
    );

    int checks = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- slave memory model ----------------
    int          wr_thr, rd_thr;
    logic [1:0]  force_bresp;
    logic        b_stall, early_rlast;
    logic [63:0] slv_mem [0:255];
    logic [7:0]  slv_wptr, slv_rptr;
    logic [3:0]  slv_rlen, slv_rbeat;
    logic        slv_ractive, slv_bpend;

    assign mst_bid = 4'hA;
    assign mst_rid = 4'h5;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mst_awready <= 1'b0; mst_wready <= 1'b0; mst_arready <= 1'b0;
            mst_bvalid  <= 1'b0; mst_bresp  <= RESP_OKAY;
            mst_rvalid  <= 1'b0; mst_rdata  <= '0; mst_rlast <= 1'b0; mst_rresp <= RESP_OKAY;
            slv_wptr <= '0; slv_rptr <= '0; slv_rlen <= '0; slv_rbeat <= '0;
            slv_ractive <= 1'b0; slv_bpend <= 1'b0;
        end else begin
            mst_awready <= ($urandom_range(99) < wr_thr);
            mst_wready  <= ($urandom_range(99) < wr_thr);
            mst_arready <= ($urandom_range(99) < rd_thr);
            if (mst_awvalid && mst_awready) slv_wptr <= mst_awaddr[10:3];
            if (mst_wvalid && mst_wready) begin
                slv_mem[slv_wptr] <= mst_wdata;
                slv_wptr <= slv_wptr + 8'd1;
                if (mst_wlast) slv_bpend <= 1'b1;
            end
            if (mst_bvalid && mst_bready) begin
                mst_bvalid <= 1'b0;
                slv_bpend  <= 1'b0;
            end else if (slv_bpend && !b_stall && !mst_bvalid) begin
                mst_bvalid <= 1'b1;
                mst_bresp  <= force_bresp;
            end
            if (mst_arvalid && mst_arready) begin
                slv_rptr <= mst_araddr[10:3]; slv_rlen <= mst_arlen;
                slv_rbeat <= '0; slv_ractive <= 1'b1;
            end
            if (mst_rvalid && mst_rready) begin
                mst_rvalid <= 1'b0;
                slv_rptr   <= slv_rptr + 8'd1;
                slv_rbeat  <= slv_rbeat + 4'd1;
                if (slv_rbeat == slv_rlen) slv_ractive <= 1'b0;
            end else if (slv_ractive && !mst_rvalid && ($urandom_range(99) < rd_thr)) begin
                mst_rvalid <= 1'b1;
                mst_rdata  <= slv_mem[slv_rptr];
                mst_rlast  <= (slv_rbeat == slv_rlen) || (early_rlast && slv_rbeat == 4'd0);
                mst_rresp  <= RESP_OKAY;
            end
        end
    end

    // ---------------- scoreboard / monitor ----------------
    logic [63:0] rd_data_q[$];
    logic        rd_last_q[$];
    logic        err_q[$];
    logic [63:0] model_mem [0:255];
    logic [31:0] exp_addr;
    logic [3:0]  exp_len;
    logic [3:0]  mon_wbeat;
    int          done_cnt = 0;
    int          exp_total = 0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (mst_awvalid && mst_awready) begin
                check_eq("awaddr", mst_awaddr, exp_addr & 32'hFFFF_FFF8);
                check_eq("awlen", mst_awlen, exp_len);
                check_eq("awsize_burst", {mst_awsize, mst_awburst}, {3'd3, BURST_INCR});
                mon_wbeat <= '0;
            end
            if (mst_arvalid && mst_arready) begin
                check_eq("araddr", mst_araddr, exp_addr & 32'hFFFF_FFF8);
                check_eq("arlen", mst_arlen, exp_len);
            end
            if (mst_wvalid && mst_wready) begin
                check_eq("wlast", mst_wlast, mon_wbeat == exp_len);
                mon_wbeat <= mon_wbeat + 4'd1;
            end
            if (rd_valid && rd_ready) begin
                if (rd_data_q.size() == 0) begin
                    check_eq("rd_unexpected", 1, 0);
                end else begin
                    check_eq("rd_data", rd_data, rd_data_q[0]);
                    check_eq("rd_last", rd_last, rd_last_q[0]);
                    void'(rd_data_q.pop_front());
                    void'(rd_last_q.pop_front());
                end
            end
            if (done) begin
                if (err_q.size() == 0) begin
                    check_eq("done_unexpected", 1, 0);
                end else begin
                    check_eq("err", err, err_q[0]);
                    void'(err_q.pop_front());
                end
                $display("txn done err=%0b t=%0t", err, $time);
                done_cnt <= done_cnt + 1;
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic issue_cmd(input logic wr, input logic [31:0] addr, input logic [3:0] len);
        int n = 0;
        exp_addr = addr; exp_len = len;
        cmd_write = wr; cmd_addr = addr; cmd_len = len; cmd_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (cmd_ready) break;
            n++;
            if (n > 200) begin check_eq("cmd_accept_timeout", 0, 1); break; end
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [3:0] len,
                            input logic [63:0] base, input logic exp_err, input int abort_beat);
        int n;
        err_q.push_back(exp_err);
        issue_cmd(1'b1, addr, len);
        for (int i = 0; i <= int'(len); i++) begin
            for (int g = 0; g < 4 && $urandom_range(99) >= wr_thr; g++) begin
                @(posedge clk); #1;
            end
            wr_valid = 1'b1;
            wr_data  = base + 64'(i);
            if (i == abort_beat) return;
            n = 0;
            forever begin
                @(negedge clk);
                if (wr_ready) break;
                n++;
                if (n > 200) begin check_eq("wr_beat_timeout", 0, 1); break; end
            end
            @(posedge clk); #1;
            wr_valid = 1'b0;
        end
        for (int i = 0; i <= int'(len); i++) model_mem[8'(addr[10:3] + 8'(i))] = base + 64'(i);
    endtask

    task automatic wait_done(input int target);
        int n = 0;
        while (done_cnt < target && n < 3000) begin
            @(posedge clk); #1;
            n++;
        end
        check_eq("done_seen", done_cnt >= target, 1);
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [3:0] len, input logic exp_err);
        int n = 0;
        for (int i = 0; i <= int'(len); i++) begin
            rd_data_q.push_back(model_mem[8'(addr[10:3] + 8'(i))]);
            rd_last_q.push_back(i == int'(len));
        end
        err_q.push_back(exp_err);
        exp_total++;
        issue_cmd(1'b0, addr, len);
        while (done_cnt < exp_total && n < 3000) begin
            rd_ready = ($urandom_range(99) < rd_thr);
            @(posedge clk); #1;
            n++;
        end
        rd_ready = 1'b0;
        check_eq("done_seen", done_cnt >= exp_total, 1);
        check_eq("rd_beats_left", rd_data_q.size(), 0);
    endtask

    task automatic write_and_wait(input logic [31:0] addr, input logic [3:0] len,
                                  input logic [63:0] base, input logic exp_err);
        do_write(addr, len, base, exp_err, -1);
        exp_total++;
        wait_done(exp_total);
    endtask

    initial begin
        rst_n = 1'b0;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
        wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b0;
        wr_thr = 100; rd_thr = 100; force_bresp = RESP_OKAY; b_stall = 1'b0; early_rlast = 1'b0;
        exp_addr = '0; exp_len = '0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_valids", {mst_awvalid, mst_arvalid, mst_wvalid, mst_bready, mst_rready, rd_valid}, 0);
        check_eq("rst_done_err", {done, err, timeout}, 0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        check_eq("cmd_ready_after_rst", cmd_ready, 1);

        // Four-beat write then read-back at full throughput.
        write_and_wait(32'h100, 4'd3, 64'd1, 1'b0);
        for (int i = 0; i < 4; i++) check_eq("mem_word", slv_mem[8'h20 + i], 64'(i + 1));
        do_read(32'h100, 4'd3, 1'b0);

        // Single-beat bursts under a throttled slave.
        wr_thr = 40; rd_thr = 40;
        write_and_wait(32'h8, 4'd0, 64'hDEAD_BEEF, 1'b0);
        check_eq("mem_len0", slv_mem[1], 64'hDEAD_BEEF);
        do_read(32'h8, 4'd0, 1'b0);

        // Slave error response, then a clean burst to the same place.
        wr_thr = 70; rd_thr = 60;
        force_bresp = RESP_SLVERR;
        write_and_wait(32'h200, 4'd1, 64'h10, 1'b1);
        force_bresp = RESP_OKAY;
        write_and_wait(32'h200, 4'd1, 64'h30, 1'b0);
        do_read(32'h200, 4'd1, 1'b0);

        // Early rlast from the slave: burst still runs all beats, err flagged.
        early_rlast = 1'b1;
        do_read(32'h100, 4'd3, 1'b1);
        early_rlast = 1'b0;

        // Unaligned start address is forced down to the word boundary.
        write_and_wait(32'h2C5, 4'd2, 64'h500, 1'b0);
        do_read(32'h2C0, 4'd2, 1'b0);

        // Reset mid-burst while the second write beat is on the bus.
        wr_thr = 100;
        do_write(32'h180, 4'd3, 64'hA0, 1'b0, 1);
        check_eq("pre_rst_wvalid", mst_wvalid, 1);
        #2; rst_n = 1'b0; #1;
        check_eq("midrst_valids", {mst_awvalid, mst_arvalid, mst_wvalid, wr_ready, mst_bready, mst_rready}, 0);
        check_eq("midrst_done_cmd_ready", {done, cmd_ready}, 2'b01);
        err_q.delete();
        wr_valid = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        check_eq("cmd_ready_after_midrst", cmd_ready, 1);
        write_and_wait(32'h180, 4'd3, 64'h70, 1'b0);
        do_read(32'h180, 4'd3, 1'b0);

        // Stalled write response for longer than the watchdog limit.
        check_eq("timeout_before_stall", timeout, 0);
        b_stall = 1'b1;
        do_write(32'h40, 4'd0, 64'h55, 1'b0, -1);
        repeat (1100) @(posedge clk);
        #1;
`ifdef AXI_BURST_MASTER_TIMEOUT_EN
        check_eq("timeout_stall", timeout, 1);
`else
        check_eq("timeout_stall", timeout, 0);
`endif
        b_stall = 1'b0;
        exp_total++;
        wait_done(exp_total);
        repeat (2) @(posedge clk);
        #1;
`ifdef AXI_BURST_MASTER_TIMEOUT_EN
        check_eq("timeout_sticky", timeout, 1);
`else
        check_eq("timeout_sticky", timeout, 0);
`endif
        check_eq("pending_err_q", err_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
